// File: rtl/dram_forward_streamer.sv
// dram_forward_streamer: DRAM read engine that prefetches a burst into a small FIFO
// and streams it to the accelerator's forward-transfer port under valid/ready.
module dram_forward_streamer #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16,
    parameter int SKID_DEPTH = 4
) (
    input  logic                  link_clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] words_num,
    input  logic [1:0]            transfer_type,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  start_forward,
    output logic [1:0]            transfer_type_out,
    output logic [ADDR_WIDTH-1:0] words_num_out,
    output logic [ADDR_WIDTH-1:0] base_addr_out,
    output logic                  valid_from_dram,
    input  logic                  re_from_dram,
    output logic [DATA_WIDTH-1:0] rdata_from_dram
);
    localparam int PW = $clog2(SKID_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d, words_q, words_d;
    logic [ADDR_WIDTH-1:0] issued_q, issued_d, accepted_q, accepted_d;
    logic [1:0]            type_q, type_d;
    logic                  sf_q, sf_d, inflight_q;
    logic [DATA_WIDTH-1:0] fifo_q [SKID_DEPTH];
    logic [PW-1:0]         wr_q, rd_q;
    logic [CW-1:0]         count_q;
    logic                  issue, push, pop;

    // Room is reserved for the read already in flight, so the FIFO cannot overflow.
    assign issue = (state_q == RUN) && (issued_q < words_q) &&
                   ((count_q + CW'(inflight_q)) < CW'(SKID_DEPTH));
    assign push  = inflight_q;
    assign pop   = valid_from_dram && re_from_dram;

    assign valid_from_dram   = count_q != '0;
    assign rdata_from_dram   = valid_from_dram ? fifo_q[rd_q] : '0;
    assign mem_en            = issue;
    assign mem_addr          = base_q + issued_q;
    assign busy              = state_q != IDLE;
    assign done              = state_q == FINISH;
    assign start_forward     = sf_q;
    assign transfer_type_out = type_q;
    assign words_num_out     = words_q;
    assign base_addr_out     = base_q;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        words_d    = words_q;
        type_d     = type_q;
        sf_d       = 1'b0;
        issued_d   = issued_q + ADDR_WIDTH'(issue);
        accepted_d = accepted_q + ADDR_WIDTH'(pop);
        case (state_q)
            IDLE: if (start) begin
                base_d     = base_addr;
                words_d    = words_num;
                type_d     = transfer_type;
                issued_d   = '0;
                accepted_d = '0;
                sf_d       = 1'b1;
                state_d    = (words_num == '0) ? FINISH : RUN;
            end
            RUN:     state_d = (accepted_d == words_q) ? FINISH : RUN;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge link_clk) begin
        if (reset) begin
            state_q    <= IDLE;
            base_q     <= '0;
            words_q    <= '0;
            type_q     <= '0;
            sf_q       <= 1'b0;
            issued_q   <= '0;
            accepted_q <= '0;
            inflight_q <= 1'b0;
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            words_q    <= words_d;
            type_q     <= type_d;
            sf_q       <= sf_d;
            issued_q   <= issued_d;
            accepted_q <= accepted_d;
            inflight_q <= issue;
            wr_q       <= wr_q + PW'(push);
            rd_q       <= rd_q + PW'(pop);
            count_q    <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge link_clk) begin
        if (push) fifo_q[wr_q] <= mem_rdata;
    end

    assert property (@(posedge link_clk) disable iff (reset)
        !(push && !pop && count_q == CW'(SKID_DEPTH)));
endmodule
